// File: rtl/add_sub_pipe.sv
// add_sub_pipe: pipelined signed add / subtract / reverse-subtract unit with a
// saturating or wrapping accumulator in the final stage. Operands are
// sign-extended by one bit, so the plain modes can never overflow. Only the
// accumulator can go out of range, and it sets a sticky ovf flag when it does.
module add_sub_pipe #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2,
  parameter bit SAT    = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  input  logic             S1,
  input  logic             S2,
  input  logic             acc_clr,
  input  logic [WIDTH-1:0] mat_L,
  input  logic [WIDTH-1:0] mat_S,
  output logic             out_valid,
  output logic [WIDTH:0]   dout,
  output logic             ovf
);

  localparam int W1 = WIDTH + 1;
  localparam int W2 = WIDTH + 2;

  localparam logic [1:0] MODE_ADD  = 2'b00;
  localparam logic [1:0] MODE_SUB  = 2'b01;
  localparam logic [1:0] MODE_RSUB = 2'b10;
  localparam logic [1:0] MODE_ACC  = 2'b11;

  // Bound for an out-of-range WIDTH+2 sum. The sign of the wide sum tells
  // which rail was crossed.
  function automatic logic [W1-1:0] clamp(input logic [W2-1:0] sum);
    logic [W1-1:0] bound;
    if (sum[W2-1] == 1'b1) begin
      bound = {1'b1, {WIDTH{1'b0}}};
    end else begin
      bound = {1'b0, {WIDTH{1'b1}}};
    end
    return bound;
  endfunction

  logic [1:0]    mode_in_s;
  logic [W1-1:0] l_ext_s;
  logic [W1-1:0] s_ext_s;
  logic [W1-1:0] term_in_s;
  logic          clr_in_s;

  assign mode_in_s = {S1, S2};
  assign l_ext_s   = {mat_L[WIDTH-1], mat_L};
  assign s_ext_s   = {mat_S[WIDTH-1], mat_S};
  // An acc_clr that arrives without in_valid is ignored.
  assign clr_in_s  = acc_clr & in_valid;

  // Entry arithmetic. The accumulate mode carries L - S as its term.
  always_comb begin
    term_in_s = l_ext_s - s_ext_s;
    case (mode_in_s)
      MODE_ADD:  term_in_s = l_ext_s + s_ext_s;
      MODE_SUB:  term_in_s = l_ext_s - s_ext_s;
      MODE_RSUB: term_in_s = s_ext_s - l_ext_s;
      MODE_ACC:  term_in_s = l_ext_s - s_ext_s;
      default:   term_in_s = l_ext_s - s_ext_s;
    endcase
  end

  // These signals feed the final stage.
  logic [W1-1:0] f_term_s;
  logic [1:0]    f_mode_s;
  logic          f_clr_s;
  logic          f_vld_s;

  if (STAGES == 1) begin : g_direct
    // With a single stage, the final stage takes the entry values directly.
    assign f_term_s = term_in_s;
    assign f_mode_s = mode_in_s;
    assign f_clr_s  = clr_in_s;
    assign f_vld_s  = in_valid;
  end else begin : g_pipe
    logic [W1-1:0] term_r [1:STAGES-1];
    logic [1:0]    mode_r [1:STAGES-1];
    logic          clr_r  [1:STAGES-1];
    logic          vld_r  [1:STAGES-1];

    // Stage 1 captures the entry values. Later stages are pure delay.
    // Reset drops every transaction that is still in flight.
    always_ff @(posedge CLK) begin
      if (RST) begin
        for (int k = 1; k < STAGES; k++) begin
          term_r[k] <= '0;
          mode_r[k] <= 2'b00;
          clr_r[k]  <= 1'b0;
          vld_r[k]  <= 1'b0;
        end
      end else begin
        term_r[1] <= term_in_s;
        mode_r[1] <= mode_in_s;
        clr_r[1]  <= clr_in_s;
        vld_r[1]  <= in_valid;
        for (int k = 2; k < STAGES; k++) begin
          term_r[k] <= term_r[k-1];
          mode_r[k] <= mode_r[k-1];
          clr_r[k]  <= clr_r[k-1];
          vld_r[k]  <= vld_r[k-1];
        end
      end
    end

    assign f_term_s = term_r[STAGES-1];
    assign f_mode_s = mode_r[STAGES-1];
    assign f_clr_s  = clr_r[STAGES-1];
    assign f_vld_s  = vld_r[STAGES-1];
  end

  logic [W1-1:0] acc_r;
  logic [W1-1:0] base_s;
  logic [W2-1:0] sum_s;
  logic          oor_s;
  logic [W1-1:0] acc_res_s;

  // Accumulate datapath. The sum is formed one bit wider than the
  // accumulator, so an out-of-range result shows up as disagreement
  // between the top two bits.
  always_comb begin
    if (f_clr_s) begin
      base_s = '0;
    end else begin
      base_s = acc_r;
    end
    sum_s = {base_s[W1-1], base_s} + {f_term_s[W1-1], f_term_s};
    oor_s = sum_s[W2-1] ^ sum_s[W2-2];
    if (oor_s && (SAT == 1'b1)) begin
      acc_res_s = clamp(sum_s);
    end else begin
      acc_res_s = sum_s[W1-1:0];
    end
  end

  // The final stage owns acc and ovf and drives the registered outputs.
  // On idle cycles, dout, acc and ovf hold their values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid <= 1'b0;
      dout      <= '0;
      ovf       <= 1'b0;
      acc_r     <= '0;
    end else if (f_vld_s) begin
      out_valid <= 1'b1;
      if (f_mode_s == MODE_ACC) begin
        acc_r <= acc_res_s;
        dout  <= acc_res_s;
        ovf   <= oor_s | (ovf & ~f_clr_s);
      end else begin
        dout <= f_term_s;
        if (f_clr_s) begin
          acc_r <= '0;
          ovf   <= 1'b0;
        end
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_add_sub_pipe.sv
// Directed testbench for add_sub_pipe. Four instances share one input bus:
// the default build, a wrapping-accumulator build, and two latency variants.
// Every expected value below was worked out by hand.
module tb_add_sub_pipe;

  logic       CLK = 1'b0;
  logic       RST;
  logic       in_valid;
  logic       S1;
  logic       S2;
  logic       acc_clr;
  logic [3:0] mat_L;
  logic [3:0] mat_S;

  logic       ov_m, ovf_m;
  logic [4:0] dout_m;
  logic       ov_w, ovf_w;
  logic [4:0] dout_w;
  logic       ov_1, ovf_1;
  logic [4:0] dout_1;
  logic       ov_4, ovf_4;
  logic [4:0] dout_4;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  add_sub_pipe #(.WIDTH(4), .STAGES(2), .SAT(1'b1)) dut_main (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .S1(S1), .S2(S2),
    .acc_clr(acc_clr), .mat_L(mat_L), .mat_S(mat_S),
    .out_valid(ov_m), .dout(dout_m), .ovf(ovf_m));

  add_sub_pipe #(.WIDTH(4), .STAGES(2), .SAT(1'b0)) dut_wrap (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .S1(S1), .S2(S2),
    .acc_clr(acc_clr), .mat_L(mat_L), .mat_S(mat_S),
    .out_valid(ov_w), .dout(dout_w), .ovf(ovf_w));

  add_sub_pipe #(.WIDTH(4), .STAGES(1), .SAT(1'b1)) dut_st1 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .S1(S1), .S2(S2),
    .acc_clr(acc_clr), .mat_L(mat_L), .mat_S(mat_S),
    .out_valid(ov_1), .dout(dout_1), .ovf(ovf_1));

  add_sub_pipe #(.WIDTH(4), .STAGES(4), .SAT(1'b1)) dut_st4 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .S1(S1), .S2(S2),
    .acc_clr(acc_clr), .mat_L(mat_L), .mat_S(mat_S),
    .out_valid(ov_4), .dout(dout_4), .ovf(ovf_4));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic drive(input logic v, input logic [1:0] m, input logic c,
                       input logic [3:0] l, input logic [3:0] s);
    in_valid = v;
    S1       = m[1];
    S2       = m[0];
    acc_clr  = c;
    mat_L    = l;
    mat_S    = s;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 1'b0, 4'h0, 4'h0);
  endtask

  initial begin
    // Reset
    RST = 1'b1;
    idle();
    idle();
    RST = 1'b0;
    chk("rst_dout", {3'b000, dout_m}, 8'h00);
    chk("rst_ov",   {7'b0, ov_m},     8'h00);
    chk("rst_ovf",  {7'b0, ovf_m},    8'h00);

    // 1. Basic modes, back to back
    drive(1'b1, 2'b00, 1'b0, 4'h1, 4'h3);   // 1 + 3
    chk("m00_lat_ov", {7'b0, ov_m}, 8'h00);
    drive(1'b1, 2'b00, 1'b0, 4'h8, 4'h8);   // -8 + -8
    chk("m00_a_ov",   {7'b0, ov_m},     8'h01);
    chk("m00_a",      {3'b000, dout_m}, 8'h04);
    drive(1'b1, 2'b01, 1'b0, 4'h7, 4'h8);   // 7 - (-8)
    chk("m00_b_ov",   {7'b0, ov_m},     8'h01);
    chk("m00_b",      {3'b000, dout_m}, 8'h10);
    drive(1'b1, 2'b10, 1'b0, 4'h8, 4'h7);   // 7 - (-8)
    chk("m01_ov",     {7'b0, ov_m},     8'h01);
    chk("m01",        {3'b000, dout_m}, 8'h0F);
    idle();
    chk("m10_ov",     {7'b0, ov_m},     8'h01);
    chk("m10",        {3'b000, dout_m}, 8'h0F);
    chk("m10_ovf",    {7'b0, ovf_m},    8'h00);
    idle();
    chk("idle_ov",    {7'b0, ov_m},     8'h00);
    chk("idle_hold",  {3'b000, dout_m}, 8'h0F);

    // 2 and 3. Accumulate: saturating (main) and wrapping (wrap)
    drive(1'b1, 2'b11, 1'b1, 4'h7, 4'h8);   // clr, +15
    drive(1'b1, 2'b11, 1'b0, 4'h1, 4'h0);   // +1, out of range
    chk("acc1_sat",   {3'b000, dout_m}, 8'h0F);
    chk("acc1_wrap",  {3'b000, dout_w}, 8'h0F);
    chk("acc1_ovf",   {7'b0, ovf_m},    8'h00);
    drive(1'b1, 2'b11, 1'b1, 4'h2, 4'h5);   // clr, 2 - 5
    chk("acc2_sat",      {3'b000, dout_m}, 8'h0F);
    chk("acc2_sat_ovf",  {7'b0, ovf_m},    8'h01);
    chk("acc2_wrap",     {3'b000, dout_w}, 8'h10);
    chk("acc2_wrap_ovf", {7'b0, ovf_w},    8'h01);
    idle();
    chk("acc3_sat",      {3'b000, dout_m}, 8'h1D);
    chk("acc3_sat_ovf",  {7'b0, ovf_m},    8'h00);
    chk("acc3_wrap",     {3'b000, dout_w}, 8'h1D);
    chk("acc3_wrap_ovf", {7'b0, ovf_w},    8'h00);

    // 4. Bubbles and interleaving
    drive(1'b1, 2'b11, 1'b1, 4'h3, 4'h0);   // clr, acc = 3
    idle();
    chk("bub_acc",  {3'b000, dout_m}, 8'h03);
    idle();
    idle();
    chk("bub_ov",   {7'b0, ov_m},     8'h00);
    drive(1'b1, 2'b00, 1'b0, 4'h1, 4'h1);
    drive(1'b1, 2'b11, 1'b0, 4'h2, 4'h0);
    chk("bub_add",  {3'b000, dout_m}, 8'h02);
    idle();
    chk("bub_acc2", {3'b000, dout_m}, 8'h05);
    chk("bub_ov2",  {7'b0, ov_m},     8'h01);

    // 5. Reset mid-flight
    drive(1'b1, 2'b11, 1'b1, 4'h7, 4'h8);   // acc = 15
    drive(1'b1, 2'b11, 1'b0, 4'h1, 4'h0);   // would overflow
    RST = 1'b1;
    idle();
    RST = 1'b0;
    chk("mid_rst_ov",   {7'b0, ov_m},     8'h00);
    chk("mid_rst_dout", {3'b000, dout_m}, 8'h00);
    chk("mid_rst_ovf",  {7'b0, ovf_m},    8'h00);
    drive(1'b1, 2'b11, 1'b0, 4'h1, 4'h0);   // no clr: acc must be 0
    chk("mid_rst_drop", {7'b0, ov_m},     8'h00);
    idle();
    chk("post_rst_ov",  {7'b0, ov_m},     8'h01);
    chk("post_rst_acc", {3'b000, dout_m}, 8'h01);
    chk("post_rst_ovf", {7'b0, ovf_m},    8'h00);
    idle();
    idle();
    idle();
    idle();

    // 6. Latency sweep
    drive(1'b1, 2'b00, 1'b0, 4'h5, 4'h2);
    chk("st1_n1_ov",   {7'b0, ov_1},     8'h01);
    chk("st1_n1_dout", {3'b000, dout_1}, 8'h07);
    chk("st4_n1_ov",   {7'b0, ov_4},     8'h00);
    idle();
    chk("st1_n2_ov",   {7'b0, ov_1},     8'h00);
    chk("st4_n2_ov",   {7'b0, ov_4},     8'h00);
    idle();
    chk("st4_n3_ov",   {7'b0, ov_4},     8'h00);
    idle();
    chk("st4_n4_ov",   {7'b0, ov_4},     8'h01);
    chk("st4_n4_dout", {3'b000, dout_4}, 8'h07);
    idle();
    chk("st4_n5_ov",   {7'b0, ov_4},     8'h00);
    chk("st4_n5_dout", {3'b000, dout_4}, 8'h07);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
